// File: rtl/ir_receiver_pkg.sv
// Shared constants for the IR frame receiver: FSM encoding, nominal pulse
// widths in 10 us ticks, register offsets and the tolerance-window helper.
package ir_receiver_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_SELECT,
        S_BITS,
        S_DONE
    } ir_state_e;

    localparam int TICK_DIV_DEF = 1000;
    localparam int START_T_DEF  = 530;
    localparam int GAP_T_DEF    = 70;
    localparam int SELECT_T_DEF = 130;
    localparam int ONE_T_DEF    = 130;
    localparam int ZERO_T_DEF   = 60;
    localparam int TOL_T_DEF    = 15;

    localparam int WIDTH_W  = 12;
    localparam int ERR_W    = 6;
    localparam int NUM_BITS = 4;

    localparam logic [7:0] OFS_COMMAND = 8'd0;
    localparam logic [7:0] OFS_STATUS  = 8'd1;

    function automatic logic width_match(input logic [WIDTH_W-1:0] w, input int nom, input int tol);
        int wi;
        wi = int'(w);
        return (wi >= nom - tol) && (wi <= nom + tol);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronises the IR envelope, flags its edges and measures the time since
// the last edge in sample ticks.
module ir_pulse_timer
    import ir_receiver_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ir,
    output logic               o_rise,
    output logic               o_fall,
    output logic [WIDTH_W-1:0] o_width
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]         r_sync;
    logic               r_last;
    logic [TW-1:0]      r_tick_cnt;
    logic [WIDTH_W-1:0] r_width;
    logic               w_tick;
    logic               w_edge;
    logic [WIDTH_W-1:0] w_width;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign o_rise = r_sync[1] & ~r_last;
    assign o_fall = ~r_sync[1] & r_last;
    assign w_edge = r_sync[1] ^ r_last;

    // Reported width includes a tick landing in the edge cycle itself, so a
    // pulse of N*TICK_DIV clocks always measures exactly N regardless of phase.
    assign w_width = (w_tick && (r_width != '1)) ? r_width + WIDTH_W'(1) : r_width;
    assign o_width = w_width;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync     <= '0;
            r_last     <= 1'b0;
            r_tick_cnt <= '0;
            r_width    <= '0;
        end else begin
            r_sync     <= {r_sync[0], i_ir};
            r_last     <= r_sync[1];
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_width    <= w_edge ? '0 : w_width;
        end
    end

endmodule

// File: rtl/ir_receiver.sv
// IR remote frame decoder with a two-register bus slave (COMMAND, STATUS)
// and a sticky frame-received interrupt.
module ir_receiver
    import ir_receiver_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h94,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int START_T  = START_T_DEF,
    parameter int GAP_T    = GAP_T_DEF,
    parameter int SELECT_T = SELECT_T_DEF,
    parameter int ONE_T    = ONE_T_DEF,
    parameter int ZERO_T   = ZERO_T_DEF,
    parameter int TOL_T    = TOL_T_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam logic [7:0]         ADDR_CMD  = BASE_ADDR + OFS_COMMAND;
    localparam logic [7:0]         ADDR_STAT = BASE_ADDR + OFS_STATUS;
    localparam logic [WIDTH_W-1:0] GAP_MAX   = WIDTH_W'(GAP_T + TOL_T);
    localparam logic [1:0]         LAST_BIT  = 2'(NUM_BITS - 1);

    ir_state_e          r_state, w_state_nx;
    logic               w_rise, w_fall;
    logic [WIDTH_W-1:0] w_width;
    logic               w_err, w_shift, w_bit, w_sel, w_done;
    logic               w_rd_cmd, w_rd_stat, w_wr_stat;
    logic               r_sel_seen;
    logic [1:0]         r_bit_cnt;
    logic [3:0]         r_cmd, r_command;
    logic               r_valid, r_ovr, r_raise, r_oe;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [7:0]         r_rdata;

    ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_ir    (IR_IN),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_width (w_width)
    );

    assign w_done    = (r_state == S_DONE);
    assign w_rd_cmd  = !BUS_WE && (BUS_ADDR == ADDR_CMD);
    assign w_rd_stat = !BUS_WE && (BUS_ADDR == ADDR_STAT);
    assign w_wr_stat = BUS_WE && (BUS_ADDR == ADDR_STAT);

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_err      = 1'b0;
        w_shift    = 1'b0;
        w_bit      = 1'b0;
        w_sel      = 1'b0;
        case (r_state)
            S_IDLE: if (w_rise) w_state_nx = S_START;
            S_START: if (w_fall) begin
                if (width_match(w_width, START_T, TOL_T)) w_state_nx = S_GAP;
                else begin w_state_nx = S_IDLE; w_err = 1'b1; end
            end
            S_GAP: begin
                // A gap that overstays its window is a dead frame, no need to wait for a burst.
                if (w_width > GAP_MAX) begin
                    w_state_nx = S_IDLE;
                    w_err      = 1'b1;
                end else if (w_rise) begin
                    if (width_match(w_width, GAP_T, TOL_T)) w_state_nx = r_sel_seen ? S_BITS : S_SELECT;
                    else begin w_state_nx = S_IDLE; w_err = 1'b1; end
                end
            end
            S_SELECT: if (w_fall) begin
                if (width_match(w_width, SELECT_T, TOL_T)) begin
                    w_state_nx = S_GAP;
                    w_sel      = 1'b1;
                end else begin w_state_nx = S_IDLE; w_err = 1'b1; end
            end
            S_BITS: if (w_fall) begin
                if (width_match(w_width, ONE_T, TOL_T) || width_match(w_width, ZERO_T, TOL_T)) begin
                    w_shift    = 1'b1;
                    w_bit      = width_match(w_width, ONE_T, TOL_T);
                    w_state_nx = (r_bit_cnt == LAST_BIT) ? S_DONE : S_GAP;
                end else begin w_state_nx = S_IDLE; w_err = 1'b1; end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sel_seen <= 1'b0;
            r_bit_cnt  <= '0;
            r_cmd      <= '0;
            r_command  <= '0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_err_cnt  <= '0;
            r_raise    <= 1'b0;
            r_oe       <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_sel_seen <= 1'b0;
                r_bit_cnt  <= '0;
            end
            if (w_sel) r_sel_seen <= 1'b1;
            if (w_shift) begin
                r_cmd     <= {r_cmd[2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 2'd1;
            end
            if (w_done) r_command <= r_cmd;

            // A frame completing alongside a COMMAND read still counts as unread.
            if (w_done)        r_valid <= 1'b1;
            else if (w_rd_cmd) r_valid <= 1'b0;

            if (w_done && r_valid) r_ovr <= 1'b1;
            else if (w_wr_stat)    r_ovr <= 1'b0;

            if (w_wr_stat)                    r_err_cnt <= '0;
            else if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);

            if (w_done)                 r_raise <= 1'b1;
            else if (BUS_INTERRUPT_ACK) r_raise <= 1'b0;

            r_oe    <= w_rd_cmd | w_rd_stat;
            r_rdata <= w_rd_cmd ? {4'b0000, r_command} : {r_valid, r_ovr, r_err_cnt};
        end
    end

    assign BUS_DATA            = r_oe ? r_rdata : 8'hzz;
    assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_ir_receiver.sv
// Randomised frame stimulus against a frame-level reference model of the
// receiver's decode rules and register side effects.
module tb_ir_receiver;

    localparam int TD   = 2;
    localparam int IDLE = 100;
    localparam logic [7:0] A_CMD  = 8'h94;
    localparam logic [7:0] A_STAT = 8'h95;

    typedef int q_t[$];

    logic       CLK = 1'b0;
    logic       RESET, IR_IN, BUS_WE, ACK, RAISE;
    logic [7:0] BUS_ADDR;
    wire  [7:0] BUS_DATA;
    logic       r_drv_en;
    logic [7:0] r_drv;

    assign BUS_DATA = r_drv_en ? r_drv : 8'hzz;
    always #5 CLK = ~CLK;

    ir_receiver #(.BASE_ADDR(8'h94), .TICK_DIV(TD)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .IR_IN               (IR_IN),
        .BUS_ADDR            (BUS_ADDR),
        .BUS_DATA            (BUS_DATA),
        .BUS_WE              (BUS_WE),
        .BUS_INTERRUPT_RAISE (RAISE),
        .BUS_INTERRUPT_ACK   (ACK)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       m_valid, m_ovr, m_raise;
    int         m_err;
    logic [3:0] m_cmd;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic bit in_tol(input int w, input int n);
        return (w >= n - 15) && (w <= n + 15);
    endfunction

    // Element 0 START, odd elements gaps, 2 SELECT, 4/6/8/10 data bits MSB first.
    function automatic bit model_frame(input q_t w, output logic [3:0] cmd);
        cmd = 4'h0;
        if (w.size() != 11) return 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) begin
                if (!in_tol(w[i], 530)) return 1'b0;
            end else if (i % 2 == 1) begin
                if (!in_tol(w[i], 70)) return 1'b0;
            end else if (i == 2) begin
                if (!in_tol(w[i], 130)) return 1'b0;
            end else if (in_tol(w[i], 130)) cmd = {cmd[2:0], 1'b1};
            else if (in_tol(w[i], 60))      cmd = {cmd[2:0], 1'b0};
            else return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_status();
        return {m_valid, m_ovr, 6'(m_err)};
    endfunction

    function automatic int jit(input int n, input bit j);
        return j ? n + int'($urandom_range(30, 0)) - 15 : n;
    endfunction

    function automatic q_t mk_frame(input logic [3:0] c, input bit j);
        q_t w;
        w.push_back(jit(530, j));
        w.push_back(jit(70, j));
        w.push_back(jit(130, j));
        for (int b = 3; b >= 0; b--) begin
            w.push_back(jit(70, j));
            w.push_back(c[b] ? jit(130, j) : jit(60, j));
        end
        return w;
    endfunction

    task automatic send(input q_t w, input bit ack_done);
        for (int i = 0; i < w.size(); i++) begin
            IR_IN = (i % 2 == 0);
            repeat (w[i] * TD) @(posedge CLK);
            #1;
        end
        IR_IN = 1'b0;
        if (ack_done) begin
            // ACK held across the cycle the frame completes: the new frame must win.
            ACK = 1'b1;
            repeat (4) @(posedge CLK);
            #1;
            ACK = 1'b0;
            chk("ack_at_done_raise", {7'b0, RAISE}, 8'h01);
            @(posedge CLK);
            #1;
            chk("ack_at_done_hold", {7'b0, RAISE}, 8'h01);
        end
        repeat (IDLE * TD) @(posedge CLK);
        #1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        BUS_ADDR = a;
        BUS_WE   = 1'b0;
        @(posedge CLK);
        #1;
        d        = BUS_DATA;
        BUS_ADDR = 8'h00;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_WE   = 1'b1;
        r_drv    = d;
        r_drv_en = 1'b1;
        @(posedge CLK);
        #1;
        BUS_WE   = 1'b0;
        r_drv_en = 1'b0;
        BUS_ADDR = 8'h00;
        if (a == A_STAT) begin
            m_ovr = 1'b0;
            m_err = 0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        bus_read(A_STAT, d);
        chk(tag, d, m_status());
    endtask

    task automatic check_cmd(input string tag);
        logic [7:0] d;
        bus_read(A_CMD, d);
        chk(tag, d, {4'b0, m_cmd});
        m_valid = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        ACK = 1'b1;
        @(posedge CLK);
        #1;
        ACK     = 1'b0;
        m_raise = 1'b0;
        chk(tag, {7'b0, RAISE}, 8'h00);
    endtask

    task automatic run_frame(input q_t w, input bit ack_done, input string tag);
        logic [3:0] c;
        send(w, ack_done);
        if (model_frame(w, c)) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_cmd   = c;
            m_raise = 1'b1;
        end else if (m_err < 63) begin
            m_err++;
        end
        chk({tag, "_raise"}, {7'b0, RAISE}, {7'b0, m_raise});
        check_status({tag, "_status"});
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_raise = 1'b0;
        m_err   = 0;
        m_cmd   = 4'h0;
    endtask

    initial begin
        q_t         q;
        logic [3:0] c;
        int         k;

        RESET    = 1'b1;
        IR_IN    = 1'b0;
        BUS_WE   = 1'b0;
        ACK      = 1'b0;
        BUS_ADDR = 8'h00;
        r_drv    = 8'h00;
        r_drv_en = 1'b0;
        model_reset();
        repeat (5) @(posedge CLK);
        #1;
        RESET = 1'b0;

        chk("rst_raise", {7'b0, RAISE}, 8'h00);
        check_status("rst_status");
        check_cmd("rst_cmd");

        // Nominal frame 1010, then ACK and COMMAND read.
        run_frame(mk_frame(4'hA, 1'b0), 1'b0, "nominal");
        do_ack("nominal_ack");
        check_cmd("nominal_cmd");
        check_status("nominal_after_read");

        // Over-long START burst.
        q = {400};
        run_frame(q, 1'b0, "long_start");

        // Gap timeout after the second data bit.
        q = mk_frame(4'h6, 1'b0);
        q = q[0:6];
        run_frame(q, 1'b0, "gap_timeout");
        check_cmd("gap_timeout_cmd");
        bus_write(A_STAT, 8'h5A);
        check_status("clear_status");

        // Two unread frames -> overrun.
        run_frame(mk_frame(4'h5, 1'b1), 1'b0, "ovr_first");
        run_frame(mk_frame(4'h3, 1'b1), 1'b0, "ovr_second");
        bus_write(A_STAT, 8'h00);
        check_status("ovr_cleared");
        check_cmd("ovr_cmd");
        do_ack("ovr_ack");

        // Tolerance edges: bits at 145/45, START 545, gaps 55 and 85.
        q = {545, 55, 115, 85, 145, 55, 45, 85, 45, 70, 145};
        run_frame(q, 1'b0, "boundary_ok");
        check_cmd("boundary_cmd");
        q = {530, 70, 130, 70, 146};
        run_frame(q, 1'b0, "boundary_146");
        do_ack("boundary_ack");

        // Frame completion with ACK asserted in the same cycle.
        run_frame(mk_frame(4'hC, 1'b0), 1'b1, "ack_at_done");
        check_cmd("ack_at_done_cmd");
        do_ack("ack_at_done_ack");

        // RESET in the middle of a data burst.
        q = {530, 70, 130, 70};
        for (int i = 0; i < q.size(); i++) begin
            IR_IN = (i % 2 == 0);
            repeat (q[i] * TD) @(posedge CLK);
            #1;
        end
        IR_IN = 1'b1;
        repeat (50 * TD) @(posedge CLK);
        #1;
        IR_IN = 1'b0;
        RESET = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        repeat (IDLE * TD) @(posedge CLK);
        #1;
        chk("midreset_raise", {7'b0, RAISE}, 8'h00);
        check_status("midreset_status");
        run_frame(mk_frame(4'h6, 1'b1), 1'b0, "post_reset");
        check_cmd("post_reset_cmd");

        // Random frames, occasionally with a corrupted burst, and random bus traffic.
        for (int f = 0; f < 6; f++) begin
            c = 4'($urandom_range(15, 0));
            q = mk_frame(c, 1'b1);
            if ($urandom_range(2, 0) == 0) begin
                k    = 2 * int'($urandom_range(5, 0));
                q[k] = int'($urandom_range(600, 20));
                q    = q[0:k];
            end
            run_frame(q, 1'b0, "rand");
            case ($urandom_range(3, 0))
                0: check_cmd("rand_cmd");
                1: do_ack("rand_ack");
                2: bus_write(A_STAT, 8'($urandom_range(255, 0)));
                default: bus_write(A_CMD, 8'($urandom_range(255, 0)));
            endcase
            check_status("rand_status");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_receiver.md
IR_RECEIVER -- requirements
Module: ir_receiver

Interface
REQ-001 Parameter BASE_ADDR, default 8'h94, meaning: the block owns BASE_ADDR (COMMAND) and BASE_ADDR+1 (STATUS).
REQ-002 Parameter TICK_DIV, default 1000, meaning: CLK cycles per 10 us sample tick.
REQ-003 Parameters START_T=530, GAP_T=70, SELECT_T=130, ONE_T=130, ZERO_T=60, TOL_T=15, meaning: nominal widths and tolerance, in ticks.
REQ-004 CLK  input  1  system clock; single clock domain.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 IR_IN  input  1  demodulated IR envelope, asynchronous, 1 = burst present.
REQ-007 BUS_ADDR  input  8  processor bus address.
REQ-008 BUS_DATA  inout  8  processor bus data; high-Z unless the block drives it per REQ-022.
REQ-009 BUS_WE  input  1  bus write enable.
REQ-010 BUS_INTERRUPT_RAISE  output  1  frame-received interrupt.
REQ-011 BUS_INTERRUPT_ACK  input  1  one-cycle interrupt acknowledge.

Function
REQ-012 Synchroniser: IR_IN SHALL pass two flops; rising and falling edges SHALL be detected on the synchronised signal.
REQ-013 Tick counter: counts 0..TICK_DIV-1; the tick pulse SHALL assert for one CLK when the counter wraps.
REQ-014 Width counter: 12 bits, cleared on every synchronised edge, incremented per tick, saturating at 4095.
REQ-015 A width matches nominal N iff N-TOL_T <= width <= N+TOL_T.
REQ-016 Frame format: START burst, gap, SELECT burst, then 4 data bursts (ONE_T = 1, ZERO_T = 0), each preceded by a gap, sent MSB first into cmd[3:0].
REQ-017 FSM states: IDLE, START, GAP, SELECT, BITS, DONE.
REQ-018 Transitions:
- IDLE -> START on rising edge.
- START -> GAP on falling edge if width matches START_T; otherwise -> IDLE with an error.
- GAP: on rising edge with width matching GAP_T, go to SELECT if SELECT has not been received yet, else to BITS; otherwise -> IDLE with an error.
- SELECT -> GAP on falling edge if width matches SELECT_T; else error.
- BITS: on falling edge, shift in 1 or 0 and go to GAP; neither width -> error; after the 4th bit -> DONE.
- DONE -> IDLE after one cycle.
REQ-019 Timeout: in GAP, a width above GAP_T+TOL_T SHALL abort to IDLE with an error.
REQ-020 In DONE: COMMAND <= {4'b0, cmd}; VALID <= 1; BUS_INTERRUPT_RAISE <= 1. If VALID was already 1, OVERRUN SHALL also be set to 1.
REQ-021 Each error SHALL increment ERR_CNT (6 bits), saturating at 63; errors SHALL NOT raise the interrupt.
REQ-022 Read: when BUS_ADDR is BASE_ADDR or BASE_ADDR+1 and BUS_WE=0, the block SHALL drive BUS_DATA in the following CLK cycle, from a registered output enable and data.
- COMMAND = {4'b0, cmd}.
- STATUS = {VALID, OVERRUN, ERR_CNT}.
REQ-023 A COMMAND read SHALL clear VALID in the cycle the data is driven.
REQ-024 Writing any value to BASE_ADDR+1 SHALL clear OVERRUN and ERR_CNT.
REQ-025 BUS_INTERRUPT_RAISE SHALL stay high until the cycle after ACK. If DONE coincides with ACK, RAISE SHALL remain 1.
REQ-026 If DONE and a COMMAND read occur in the same cycle, the new frame wins: VALID=1, OVERRUN unchanged.

Reset
REQ-027 RESET SHALL force the following state:
- FSM = IDLE; all counters = 0; cmd = 0; COMMAND = 0; VALID = OVERRUN = 0.
- BUS_INTERRUPT_RAISE = 0; BUS_DATA = high-Z; synchroniser flops = 0.
REQ-028 RESET mid-frame SHALL discard the partial frame without counting an error.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, the tick and width constants, and the register offsets.
REQ-030 One sub-module, ir_pulse_timer (synchroniser, edge detect, tick counter, width counter), SHALL feed the FSM.

Verification
REQ-031 Nominal frame, bits 1010 -> COMMAND=8'h0A, VALID=1, RAISE=1; ACK -> RAISE=0 the next cycle; COMMAND read -> 8'h0A, VALID=0.
REQ-032 START burst of 400 ticks -> FSM returns to IDLE, ERR_CNT=1, RAISE stays 0.
REQ-033 Gap exceeding 85 ticks after the 2nd bit -> abort, ERR_CNT increments, COMMAND unchanged.
REQ-034 Two frames with no read in between -> STATUS reads 8'hC0 (VALID=1, OVERRUN=1, ERR_CNT=0); write to STATUS -> OVERRUN=0.
REQ-035 Boundary widths: ONE at 145 ticks and ZERO at 45 ticks are accepted; 146 ticks is an error.
REQ-036 RESET asserted during BITS -> IDLE, ERR_CNT=0; a subsequent clean frame decodes correctly.
